// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared
// datapath / unified memory port.
interface multicycle_controller_if;
    logic [6:0] op;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       IllegalInstr;
    logic [3:0] State;

    modport master (
        input  op, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
        output ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegWrite,
        output IllegalInstr, State
    );

    modport slave (
        output op, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
        input  ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegWrite,
        input  IllegalInstr, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// RV32I multicycle control FSM: sequences fetch/decode/execute/memory/
// writeback over a shared datapath with a ready-handshaked memory port.
module multicycle_controller #(
    parameter bit WAIT_MEM = 1'b1
) (
    input logic                    clk,
    input logic                    reset,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t state_q, state_d;
    logic   mem_ready;
    logic   pc_update;
    logic   branch;

    assign mem_ready = WAIT_MEM ? bus.MemReady : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        case (bus.op)
            OP_LW, OP_I: bus.ImmSrc = 2'b00;
            OP_SW:       bus.ImmSrc = 2'b01;
            OP_BEQ:      bus.ImmSrc = 2'b10;
            OP_JAL:      bus.ImmSrc = 2'b11;
            default:     bus.ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        pc_update        = 1'b0;
        branch           = 1'b0;
        bus.AdrSrc       = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.ResultSrc    = 2'b00;
        bus.ALUSrcA      = 2'b00;
        bus.ALUSrcB      = 2'b00;
        bus.ALUOp        = 2'b00;
        bus.RegWrite     = 1'b0;
        bus.IllegalInstr = 1'b0;
        case (state_q)
            FETCH: begin
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = mem_ready;
                pc_update     = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                // Branch target PC+imm is parked in ALUOut here.
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = TRAP;
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                state_d     = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                bus.AdrSrc = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
                state_d       = FETCH;
            end
            MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXECUTER: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b10;
                state_d     = ALUWB;
            end
            EXECUTEI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = 2'b10;
                state_d     = ALUWB;
            end
            ALUWB: begin
                bus.RegWrite = 1'b1;
                state_d      = FETCH;
            end
            BEQ: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b01;
                branch      = 1'b1;
                state_d     = FETCH;
            end
            JAL: begin
                // PC <- target while OldPC+4 heads to rd via ALUWB.
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                pc_update   = 1'b1;
                state_d     = ALUWB;
            end
            TRAP: begin
                bus.IllegalInstr = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    assign bus.PCWrite = pc_update | (branch & bus.Zero);
    assign bus.State   = state_q;
endmodule
